// File: rtl/dcs_switch_ctrl.sv
// DCS clock-switch sequencer: break-before-make hand-over of SEL0/SEL1, done after SETTLE_EDGES target edges; req_ready only in IDLE.
// Latency: done 1 cycle after accept for the current clock, else DRAIN_CYCLES + settle; DCS_SWITCH_TIMEOUT_EN adds a dead-clock abort on err.
module dcs_switch_ctrl #(
   parameter int DRAIN_CYCLES   = 4,
   parameter int SETTLE_EDGES   = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic ref_clk,
   input  logic sel_clk0_rstn,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   input  logic clk0_mon,
   input  logic clk1_mon,
   output logic sel0,
   output logic sel1,
   output logic modesel,
   output logic active_clk,
   output logic done,
   output logic err
);

   localparam int DRAIN_N  = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
   localparam int SETTLE_N = (SETTLE_EDGES < 1) ? 1 : SETTLE_EDGES;
   localparam int DW       = $clog2(DRAIN_N + 1);
   localparam int EW       = $clog2(SETTLE_N + 1);
   localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_N - 1);
   localparam logic [EW-1:0] SETTLE_LAST = EW'(SETTLE_N - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      SETTLE = 2'd2,
      ABORT  = 2'd3
   } state_t;

   state_t          state, state_n;
   logic            tgt, tgt_n;
   logic            sel0_n, sel1_n, act_n, done_n;
   logic [DW-1:0]   dcnt, dcnt_n;
   logic [EW-1:0]   ecnt, ecnt_n;
   logic [1:0]      rst_sync;
   logic            rstn;
   logic [2:0]      mon0_sync, mon1_sync;
   logic            edge0, edge1, tgt_edge;

`ifdef DCS_SWITCH_TIMEOUT_EN
   localparam int TIMEOUT_N = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
   localparam int TW        = $clog2(TIMEOUT_N + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_N - 1);
   logic [TW-1:0]   tcnt, tcnt_n;
   logic            err_q, err_n;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Reset asserts immediately, releases two ref_clk edges later.
   always_ff @(posedge ref_clk or negedge sel_clk0_rstn) begin
      if (!sel_clk0_rstn) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end
   assign rstn = rst_sync[1];

   always_ff @(posedge ref_clk or negedge rstn) begin
      if (!rstn) begin
         mon0_sync <= 3'b000;
         mon1_sync <= 3'b000;
      end else begin
         mon0_sync <= {mon0_sync[1:0], clk0_mon};
         mon1_sync <= {mon1_sync[1:0], clk1_mon};
      end
   end

   assign edge0    = mon0_sync[1] & ~mon0_sync[2];
   assign edge1    = mon1_sync[1] & ~mon1_sync[2];
   assign tgt_edge = tgt ? edge1 : edge0;

   assign req_ready = (state == IDLE);
   assign modesel   = 1'b0;

   always_ff @(posedge ref_clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         tgt        <= 1'b0;
         sel0       <= 1'b1;
         sel1       <= 1'b0;
         active_clk <= 1'b0;
         done       <= 1'b0;
         dcnt       <= '0;
         ecnt       <= '0;
`ifdef DCS_SWITCH_TIMEOUT_EN
         tcnt       <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         tgt        <= tgt_n;
         sel0       <= sel0_n;
         sel1       <= sel1_n;
         active_clk <= act_n;
         done       <= done_n;
         dcnt       <= dcnt_n;
         ecnt       <= ecnt_n;
`ifdef DCS_SWITCH_TIMEOUT_EN
         tcnt       <= tcnt_n;
         err_q      <= err_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      tgt_n   = tgt;
      sel0_n  = sel0;
      sel1_n  = sel1;
      act_n   = active_clk;
      done_n  = 1'b0;
      dcnt_n  = dcnt;
      ecnt_n  = ecnt;
`ifdef DCS_SWITCH_TIMEOUT_EN
      tcnt_n  = tcnt;
      err_n   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_sel == active_clk) begin
                  done_n = 1'b1;
               end else begin
                  state_n = DRAIN;
                  tgt_n   = req_sel;
                  sel0_n  = 1'b0;
                  sel1_n  = 1'b0;
                  dcnt_n  = '0;
               end
            end
         end
         DRAIN: begin
            if (dcnt == DRAIN_LAST) begin
               sel0_n  = ~tgt;
               sel1_n  = tgt;
               state_n = SETTLE;
               ecnt_n  = '0;
`ifdef DCS_SWITCH_TIMEOUT_EN
               tcnt_n  = '0;
`endif
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         SETTLE: begin
            if (tgt_edge) begin
               if (ecnt == SETTLE_LAST) begin
                  act_n   = tgt;
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  ecnt_n = ecnt + 1'b1;
               end
`ifdef DCS_SWITCH_TIMEOUT_EN
               tcnt_n = '0;
            end else if (tcnt == TIMEOUT_LAST) begin
               // Dead target: break again before restoring the old select.
               sel0_n  = 1'b0;
               sel1_n  = 1'b0;
               dcnt_n  = '0;
               state_n = ABORT;
            end else begin
               tcnt_n = tcnt + 1'b1;
`endif
            end
         end
`ifdef DCS_SWITCH_TIMEOUT_EN
         ABORT: begin
            if (dcnt == DRAIN_LAST) begin
               sel0_n  = ~active_clk;
               sel1_n  = active_clk;
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
`endif
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dcs_switch_ctrl.sv
// Bench for dcs_switch_ctrl: random switch requests against a transaction-level model of drain/settle timing.
module tb_dcs_switch_ctrl;

   localparam int D = 4;
   localparam int S = 8;
   localparam int T = 255;

   logic ref_clk;
   logic sel_clk0_rstn;
   logic req_valid;
   logic req_sel;
   logic req_ready;
   logic clk0_mon;
   logic clk1_mon;
   logic sel0;
   logic sel1;
   logic modesel;
   logic active_clk;
   logic done;
   logic err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int h0    = 3;
   int h1    = 2;
   int p0    = 0;
   int p1    = 0;
   bit model_act = 1'b0;
   bit hist0 [0:32767];
   bit hist1 [0:32767];

   dcs_switch_ctrl #(
      .DRAIN_CYCLES   (D),
      .SETTLE_EDGES   (S),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .ref_clk       (ref_clk),
      .sel_clk0_rstn (sel_clk0_rstn),
      .req_valid     (req_valid),
      .req_sel       (req_sel),
      .req_ready     (req_ready),
      .clk0_mon      (clk0_mon),
      .clk1_mon      (clk1_mon),
      .sel0          (sel0),
      .sel1          (sel1),
      .modesel       (modesel),
      .active_clk    (active_clk),
      .done          (done),
      .err           (err)
   );

   initial begin
      ref_clk = 1'b0;
      forever #5 ref_clk = ~ref_clk;
   end

   // Monitor clocks change on the falling edge with a half period of h ref cycles; h==0 freezes them.
   always @(negedge ref_clk) begin
      if (h0 != 0) begin
         p0 = p0 + 1;
         if (p0 >= h0) begin
            p0 = 0;
            clk0_mon = ~clk0_mon;
         end
      end
      if (h1 != 0) begin
         p1 = p1 + 1;
         if (p1 >= h1) begin
            p1 = 0;
            clk1_mon = ~clk1_mon;
         end
      end
   end

   always @(posedge ref_clk) begin
      cyc = cyc + 1;
      if (cyc < 32768) begin
         hist0[cyc] = clk0_mon;
         hist1[cyc] = clk1_mon;
      end
   end

   // A raw rise first sampled high at edge k is counted by the FSM at edge k+2.
   function automatic bit edge_at(input bit s, input int n);
      if (s) return hist1[n-2] && !hist1[n-3];
      return hist0[n-2] && !hist0[n-3];
   endfunction

   always @(negedge ref_clk) begin
      total = total + 1;
      if ((sel0 && sel1) || (done && err) || modesel !== 1'b0) begin
         bad = bad + 1;
         $display("FAIL invariant cyc=%0d sel0=%b sel1=%b done=%b err=%b modesel=%b", cyc, sel0, sel1, done, err, modesel);
      end
`ifndef DCS_SWITCH_TIMEOUT_EN
      total = total + 1;
      if (err !== 1'b0) begin
         bad = bad + 1;
         $display("FAIL err_tied cyc=%0d err=%b expected 0", cyc, err);
      end
`endif
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (3) @(negedge ref_clk);
      total++;
      if ({sel0, sel1, modesel, active_clk, req_ready, done, err} !== 7'b1000100) begin
         bad++;
         $display("FAIL reset_hold got=%b expected=1000100", {sel0, sel1, modesel, active_clk, req_ready, done, err});
      end
      sel_clk0_rstn = 1'b1;
      repeat (3) @(negedge ref_clk);
      total++;
      if ({sel0, sel1, modesel, active_clk, req_ready, done, err} !== 7'b1000100) begin
         bad++;
         $display("FAIL reset_release got=%b expected=1000100", {sel0, sel1, modesel, active_clk, req_ready, done, err});
      end
   endtask

   task automatic test_first_switch();
      int a, n, edges;
      bit fin;
      h1 = 2;
      @(negedge ref_clk);
      req_valid = 1'b1;
      req_sel   = 1'b1;
      @(negedge ref_clk);
      req_valid = 1'b0;
      a = cyc;
      total++;
      if (sel0 !== 1'b0 || sel1 !== 1'b0 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL first_sel0_fall sel0=%b sel1=%b ready=%b expected 0 0 0", sel0, sel1, req_ready);
      end
      repeat (D - 1) @(negedge ref_clk);
      total++;
      if (sel1 !== 1'b0) begin
         bad++;
         $display("FAIL first_sel1_early cyc=%0d sel1=%b expected 0", cyc - a, sel1);
      end
      @(negedge ref_clk);
      total++;
      if (sel1 !== 1'b1 || sel0 !== 1'b0) begin
         bad++;
         $display("FAIL first_sel1_rise cyc=%0d sel0=%b sel1=%b expected 0 1", cyc - a, sel0, sel1);
      end
      edges = 0;
      fin   = 1'b0;
      for (int w = 0; w < 200 && !fin; w++) begin
         @(negedge ref_clk);
         n = cyc;
         if (edge_at(1'b1, n)) edges++;
         total++;
         if (edges == S) begin
            fin = 1'b1;
            if (done !== 1'b1 || active_clk !== 1'b1 || req_ready !== 1'b1) begin
               bad++;
               $display("FAIL first_done done=%b active=%b ready=%b expected 1 1 1", done, active_clk, req_ready);
            end
         end else if (done !== 1'b0 || active_clk !== 1'b0) begin
            bad++;
            $display("FAIL first_settle edges=%0d done=%b active=%b expected 0 0", edges, done, active_clk);
         end
      end
      if (!fin) begin
         total++;
         bad++;
         $display("FAIL first_timeout no completion within bound, edges=%0d required=%0d", edges, S);
      end
      model_act = 1'b1;
   endtask

   task automatic test_random();
      for (int t = 0; t < 20; t++) begin
         bit s, pulse, fin;
         int a, n, edges, pk;
         h0    = $urandom_range(2, 5);
         h1    = $urandom_range(2, 5);
         s     = 1'($urandom_range(0, 1));
         pulse = 1'($urandom_range(0, 1));
         pk    = $urandom_range(0, D - 1);
         repeat ($urandom_range(0, 3)) @(negedge ref_clk);
         total++;
         if (req_ready !== 1'b1 || sel0 !== !model_act || sel1 !== model_act || active_clk !== model_act) begin
            bad++;
            $display("FAIL rand_idle t=%0d ready=%b sel0=%b sel1=%b active=%b expected active=%b", t, req_ready, sel0, sel1, active_clk, model_act);
         end
         req_valid = 1'b1;
         req_sel   = s;
         @(negedge ref_clk);
         req_valid = 1'b0;
         a = cyc;
         if (s == model_act) begin
            total++;
            if (done !== 1'b1 || sel0 !== !model_act || sel1 !== model_act) begin
               bad++;
               $display("FAIL rand_same t=%0d done=%b sel0=%b sel1=%b expected done=1 active=%b", t, done, sel0, sel1, model_act);
            end
         end else begin
            for (int k = 0; k < D; k++) begin
               if (k > 0) @(negedge ref_clk);
               req_valid = 1'b0;
               total++;
               if ({sel0, sel1, done, req_ready} !== 4'b0000) begin
                  bad++;
                  $display("FAIL rand_drain t=%0d k=%0d got=%b expected=0000", t, k, {sel0, sel1, done, req_ready});
               end
               if (pulse && k == pk) begin
                  req_valid = 1'b1;
                  req_sel   = 1'($urandom);
               end
            end
            @(negedge ref_clk);
            req_valid = 1'b0;
            total++;
            if (sel0 !== !s || sel1 !== s || done !== 1'b0) begin
               bad++;
               $display("FAIL rand_raise t=%0d sel0=%b sel1=%b done=%b expected target=%b", t, sel0, sel1, done, s);
            end
            edges = 0;
            fin   = 1'b0;
            for (int w = 0; w < 300 && !fin; w++) begin
               @(negedge ref_clk);
               n = cyc;
               if (edge_at(s, n)) edges++;
               total++;
               if (edges == S) begin
                  fin = 1'b1;
                  if (done !== 1'b1 || active_clk !== s || sel0 !== !s || sel1 !== s) begin
                     bad++;
                     $display("FAIL rand_done t=%0d done=%b active=%b expected done=1 active=%b", t, done, active_clk, s);
                  end
               end else if (done !== 1'b0 || active_clk !== model_act || sel1 !== s) begin
                  bad++;
                  $display("FAIL rand_settle t=%0d edges=%0d done=%b active=%b sel1=%b expected 0 %b %b", t, edges, done, active_clk, sel1, model_act, s);
               end
            end
            if (!fin) begin
               total++;
               bad++;
               $display("FAIL rand_timeout t=%0d edges=%0d required=%0d", t, edges, S);
            end
            model_act = s;
         end
      end
   endtask

   task automatic test_drop_in_drain();
      bit s;
      int ndone;
      s  = !model_act;
      h0 = 3;
      h1 = 3;
      @(negedge ref_clk);
      req_valid = 1'b1;
      req_sel   = s;
      @(negedge ref_clk);
      req_valid = 1'b0;
      @(negedge ref_clk);
      total++;
      if (req_ready !== 1'b0) begin
         bad++;
         $display("FAIL drop_ready ready=%b expected 0", req_ready);
      end
      req_valid = 1'b1;
      req_sel   = !s;
      @(negedge ref_clk);
      req_valid = 1'b0;
      ndone = 0;
      for (int w = 0; w < 150; w++) begin
         if (done === 1'b1) ndone++;
         @(negedge ref_clk);
      end
      total++;
      if (ndone != 1) begin
         bad++;
         $display("FAIL drop_done_count got=%0d expected=1", ndone);
      end
      total++;
      if (active_clk !== s || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL drop_final active=%b ready=%b expected %b 1", active_clk, req_ready, s);
      end
      model_act = s;
   endtask

   task automatic test_reset_in_settle();
      bit s;
      s  = !model_act;
      h0 = 5;
      h1 = 5;
      @(negedge ref_clk);
      req_valid = 1'b1;
      req_sel   = s;
      @(negedge ref_clk);
      req_valid = 1'b0;
      repeat (D + 2) @(negedge ref_clk);
      total++;
      if (req_ready !== 1'b0 || sel0 !== !s || sel1 !== s) begin
         bad++;
         $display("FAIL rst_settle_pre ready=%b sel0=%b sel1=%b expected 0 target=%b", req_ready, sel0, sel1, s);
      end
      #2 sel_clk0_rstn = 1'b0;
      #1;
      total++;
      if ({sel0, sel1, active_clk, req_ready, done, err} !== 6'b100100) begin
         bad++;
         $display("FAIL rst_settle_async got=%b expected=100100", {sel0, sel1, active_clk, req_ready, done, err});
      end
      repeat (3) @(negedge ref_clk);
      sel_clk0_rstn = 1'b1;
      model_act     = 1'b0;
      repeat (4) @(negedge ref_clk);
      total++;
      if ({sel0, sel1, active_clk, req_ready, done} !== 5'b10010) begin
         bad++;
         $display("FAIL rst_settle_after got=%b expected=10010", {sel0, sel1, active_clk, req_ready, done});
      end
   endtask

   task automatic test_same_clk();
      @(negedge ref_clk);
      req_valid = 1'b1;
      req_sel   = model_act;
      @(negedge ref_clk);
      req_valid = 1'b0;
      total++;
      if (done !== 1'b1 || sel0 !== !model_act || sel1 !== model_act || active_clk !== model_act) begin
         bad++;
         $display("FAIL same_done done=%b sel0=%b sel1=%b active=%b expected done=1 active=%b", done, sel0, sel1, active_clk, model_act);
      end
      @(negedge ref_clk);
      total++;
      if (done !== 1'b0 || req_ready !== 1'b1 || sel0 !== !model_act) begin
         bad++;
         $display("FAIL same_after done=%b ready=%b sel0=%b expected 0 1 %b", done, req_ready, sel0, !model_act);
      end
   endtask

`ifdef DCS_SWITCH_TIMEOUT_EN
   task automatic test_timeout();
      int a, n;
      bit [1:0] es;
      bit ee;
      h1 = 0;
      h0 = 3;
      repeat (10) @(negedge ref_clk);
      req_valid = 1'b1;
      req_sel   = 1'b1;
      @(negedge ref_clk);
      req_valid = 1'b0;
      a = cyc;
      for (int w = 0; w < 2 * D + T + 3; w++) begin
         if (w > 0) @(negedge ref_clk);
         n = cyc;
         if (n < a + D)              es = 2'b00;
         else if (n < a + D + T)     es = 2'b01;
         else if (n < a + 2 * D + T) es = 2'b00;
         else                        es = 2'b10;
         ee = (n == a + 2 * D + T);
         total++;
         if ({sel0, sel1} !== es || err !== ee || done !== 1'b0 || active_clk !== 1'b0) begin
            bad++;
            $display("FAIL timeout cyc=%0d sel=%b err=%b done=%b active=%b expected sel=%b err=%b done=0 active=0", n - a, {sel0, sel1}, err, done, active_clk, es, ee);
         end
      end
   endtask
`endif

   initial begin
      sel_clk0_rstn = 1'b0;
      req_valid     = 1'b0;
      req_sel       = 1'b0;
      clk0_mon      = 1'b0;
      clk1_mon      = 1'b0;
      test_reset();
      test_first_switch();
      test_random();
      test_drop_in_drain();
      test_reset_in_settle();
      test_same_clk();
`ifdef DCS_SWITCH_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(negedge ref_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcs_switch_ctrl.md
DCS_SWITCH_CTRL -- requirements
Module: dcs_switch_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, 4: ref_clk cycles with both selects low before the target select is raised; a value of 0 behaves as 1.
REQ-002 SHALL have parameter SETTLE_EDGES, 8: synchronized rising edges of the target clock required before the switch completes; a value of 0 behaves as 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 255: ref_clk cycles allowed without a target-clock edge (used only with DCS_SWITCH_TIMEOUT_EN).
REQ-004 SHALL have port ref_clk  input  1  free-running controller clock; all state is on its rising edge.
REQ-005 SHALL have port sel_clk0_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  switch request strobe.
REQ-007 SHALL have port req_sel  input  1  target clock: 0=CLK0, 1=CLK1.
REQ-008 SHALL have port req_ready  output  1  high when a request can be accepted.
REQ-009 SHALL have port clk0_mon / clk1_mon  input  1 each  raw DCS input clocks, for activity sensing only.
REQ-010 SHALL have port sel0 / sel1  output  1 each  drive the DCS SEL0/SEL1 pins.
REQ-011 SHALL have port modesel  output  1  drives the DCS MODESEL pin.
REQ-012 SHALL have port active_clk  output  1  currently selected clock (0/1).
REQ-013 SHALL have port done  output  1  one-cycle pulse when a request completes.
REQ-014 SHALL have port err  output  1  one-cycle pulse when a switch aborts.

Function
REQ-015 SHALL accept a request when req_valid && req_ready; requests arriving while req_ready is low SHALL be dropped.
REQ-016 SHALL implement the states IDLE -> DRAIN -> SETTLE -> IDLE; req_ready SHALL be high only in IDLE.
REQ-017 SHALL pulse done on the cycle after acceptance when req_sel==active_clk, with no change to sel0/sel1.
REQ-018 SHALL, otherwise, enter DRAIN and drive sel0=sel1=0 on the cycle after acceptance.
REQ-019 SHALL remain in DRAIN for exactly max(DRAIN_CYCLES,1) cycles, then raise the target select (sel0 for CLK0, sel1 for CLK1) and enter SETTLE.
REQ-020 SHALL sample the target monitor clock through a 2-flop synchronizer and count its rising edges in SETTLE.
REQ-021 SHALL, on reaching max(SETTLE_EDGES,1) edges, update active_clk, pulse done, and return to IDLE in the same cycle.
REQ-022 SHALL never assert sel0 and sel1 together; modesel SHALL be held at 0.
REQ-023 SHALL restart the edge counter only on SETTLE entry; the counter width SHALL hold SETTLE_EDGES without wrap-around.
REQ-024 SHALL require each monitored clock to have a frequency below ref_clk/2 (integration constraint).

Reset
REQ-025 SHALL, while sel_clk0_rstn=0, force sel0=1, sel1=0, modesel=0, active_clk=0, req_ready=1, done=0, err=0, state=IDLE, and all counters to 0.
REQ-026 SHALL, on reset assertion mid-switch, abandon the switch immediately and return the outputs to the CLK0 reset values.
REQ-027 SHALL release reset synchronously to ref_clk (2-flop release synchronizer).

Configuration
REQ-028 SHALL, with DCS_SWITCH_TIMEOUT_EN defined, abort when TIMEOUT_CYCLES ref_clk cycles pass in SETTLE without a target edge; the abort SHALL drive both selects low for DRAIN_CYCLES, re-raise the previous select, pulse err (not done), leave active_clk unchanged, and return to IDLE.
REQ-029 SHALL, without DCS_SWITCH_TIMEOUT_EN, wait in SETTLE indefinitely; err SHALL be tied to 0 and no timeout counter SHALL be built.

Verification
REQ-030 SHALL cover: reset release, then req_sel=1 with CLK1 toggling at ref/4 -> sel0 falls at +1 cycle, sel1 rises 4 cycles later, done after 8 synchronized CLK1 edges, active_clk=1.
REQ-031 SHALL cover: req_sel=0 while active_clk=0 -> done on the next cycle, sel0 stays 1, sel1 stays 0.
REQ-032 SHALL cover: req_valid pulsed during DRAIN -> request dropped, exactly one done pulse.
REQ-033 SHALL cover: sel_clk0_rstn asserted in SETTLE -> sel0=1, sel1=0, active_clk=0 asynchronously.
REQ-034 SHALL cover, with DCS_SWITCH_TIMEOUT_EN: CLK1 held static, req_sel=1 -> err after 255 SETTLE cycles, sel0 restored to 1, active_clk=0.
REQ-035 SHALL cover: continuous assertion check that sel0&&sel1 is never true and that done and err are never asserted together.
